// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the RV32I core: result-mux and ALU opcode
// encodings plus the packed control bundle carried between pipeline registers.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_PCT = 2'b11
  } res_src_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_SRL  = 4'b1101,
    ALU_SLL  = 4'b1110,
    ALU_SRA  = 4'b1111
  } alu_ctrl_e;

  // Fields stay plain logic vectors so undefined decoder encodings can be scrubbed.
  typedef struct packed {
    logic [1:0] res_src;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       branch;
    logic [3:0] alu_control;
    logic [2:0] f3;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_sanitize.sv
// Combinational X-scrub of the control bundle: 1-bit fields pass only a solid 1,
// multi-bit fields containing X/Z collapse to zero. Transparent after synthesis.
module ctrl_sanitize
  import rv_pipe_pkg::*;
(
  input  ctrl_bundle_t i_ctrl,
  output ctrl_bundle_t o_ctrl
);

  always_comb begin
    o_ctrl             = CTRL_BUBBLE;
    o_ctrl.mem_write   = (i_ctrl.mem_write === 1'b1);
    o_ctrl.alu_src     = (i_ctrl.alu_src   === 1'b1);
    o_ctrl.reg_write   = (i_ctrl.reg_write === 1'b1);
    o_ctrl.jump        = (i_ctrl.jump      === 1'b1);
    o_ctrl.branch      = (i_ctrl.branch    === 1'b1);
    // A reduction XOR yields X whenever any bit of the field is X or Z.
    o_ctrl.res_src     = ((^i_ctrl.res_src)     === 1'bx) ? 2'b00   : i_ctrl.res_src;
    o_ctrl.alu_control = ((^i_ctrl.alu_control) === 1'bx) ? 4'b0000 : i_ctrl.alu_control;
    o_ctrl.f3          = ((^i_ctrl.f3)          === 1'bx) ? 3'b000  : i_ctrl.f3;
  end

endmodule

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with hold, flush-to-bubble and valid bit.
// Define ID_EX_PERF_CNT_EN to add the BUBBLE_CNT / STALL_CNT event counters.
module id_ex_reg
  import rv_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN_E,
  input  logic              FLUSH_E,
  input  logic              VALID_D,
  input  logic [1:0]        RES_SRC_D,
  input  logic              MEM_WRITE_D,
  input  logic              ALU_SRC_D,
  input  logic              REG_WRITE_D,
  input  logic              JUMP_D,
  input  logic              BRANCH_D,
  input  logic [3:0]        ALU_CONTROL_D,
  input  logic [2:0]        F3_D,
  input  logic [XLEN-1:0]   RD1_D,
  input  logic [XLEN-1:0]   RD2_D,
  input  logic [XLEN-1:0]   PC_D,
  input  logic [XLEN-1:0]   PC_PLUS4_D,
  input  logic [XLEN-1:0]   IMM_EXT_D,
  input  logic [REG_AW-1:0] RS1_D,
  input  logic [REG_AW-1:0] RS2_D,
  input  logic [REG_AW-1:0] RD_D,
  output logic              VALID_E,
  output logic [1:0]        RES_SRC_E,
  output logic              MEM_WRITE_E,
  output logic              ALU_SRC_E,
  output logic              REG_WRITE_E,
  output logic              JUMP_E,
  output logic              BRANCH_E,
  output logic [3:0]        ALU_CONTROL_E,
  output logic [2:0]        F3_E,
  output logic [XLEN-1:0]   RD1_E,
  output logic [XLEN-1:0]   RD2_E,
  output logic [XLEN-1:0]   PC_E,
  output logic [XLEN-1:0]   PC_PLUS4_E,
  output logic [XLEN-1:0]   IMM_EXT_E,
  output logic [REG_AW-1:0] RS1_E,
  output logic [REG_AW-1:0] RS2_E,
  output logic [REG_AW-1:0] RD_E
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       BUBBLE_CNT,
  output logic [31:0]       STALL_CNT
`endif
);

  ctrl_bundle_t w_ctrl_d;
  ctrl_bundle_t w_ctrl_s;
  logic         w_valid_d;
  logic         w_load_bubble;
  logic         w_capture;

  ctrl_bundle_t      r_ctrl;
  logic              r_valid;
  logic [XLEN-1:0]   r_rd1;
  logic [XLEN-1:0]   r_rd2;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_pc4;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;

  assign w_ctrl_d = '{
    res_src:     RES_SRC_D,
    mem_write:   MEM_WRITE_D,
    alu_src:     ALU_SRC_D,
    reg_write:   REG_WRITE_D,
    jump:        JUMP_D,
    branch:      BRANCH_D,
    alu_control: ALU_CONTROL_D,
    f3:          F3_D
  };

  ctrl_sanitize u_ctrl_sanitize (
    .i_ctrl (w_ctrl_d),
    .o_ctrl (w_ctrl_s)
  );

  assign w_valid_d     = (VALID_D === 1'b1);
  // An empty D slot is captured as a bubble so indices never alias a real rd.
  assign w_load_bubble = FLUSH_E | (EN_E & ~w_valid_d);
  assign w_capture     = ~FLUSH_E & EN_E & w_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_BUBBLE;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_imm   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
    end else if (w_load_bubble) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_BUBBLE;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_imm   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_ctrl  <= w_ctrl_s;
      r_rd1   <= RD1_D;
      r_rd2   <= RD2_D;
      r_pc    <= PC_D;
      r_pc4   <= PC_PLUS4_D;
      r_imm   <= IMM_EXT_D;
      r_rs1   <= RS1_D;
      r_rs2   <= RS2_D;
      r_rd    <= RD_D;
    end
  end

  assign VALID_E       = r_valid;
  assign RES_SRC_E     = r_ctrl.res_src;
  assign MEM_WRITE_E   = r_ctrl.mem_write;
  assign ALU_SRC_E     = r_ctrl.alu_src;
  assign REG_WRITE_E   = r_ctrl.reg_write;
  assign JUMP_E        = r_ctrl.jump;
  assign BRANCH_E      = r_ctrl.branch;
  assign ALU_CONTROL_E = r_ctrl.alu_control;
  assign F3_E          = r_ctrl.f3;
  assign RD1_E         = r_rd1;
  assign RD2_E         = r_rd2;
  assign PC_E          = r_pc;
  assign PC_PLUS4_E    = r_pc4;
  assign IMM_EXT_E     = r_imm;
  assign RS1_E         = r_rs1;
  assign RS2_E         = r_rs2;
  assign RD_E          = r_rd;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = ~EN_E & ~FLUSH_E;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_load_bubble) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_stall)       r_stall_cnt  <= r_stall_cnt + 32'd1;
    end
  end

  assign BUBBLE_CNT = r_bubble_cnt;
  assign STALL_CNT  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios followed by a randomized
// run checked through an expected-value queue and an independent monitor.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [1:0]  res_src;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic        jump;
    logic        branch;
    logic [3:0]  alu_control;
    logic [2:0]  f3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } slot_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  en = 1'b0;
  logic  fl = 1'b0;
  slot_t d = '0;

  logic        VALID_E;
  logic [1:0]  RES_SRC_E;
  logic        MEM_WRITE_E;
  logic        ALU_SRC_E;
  logic        REG_WRITE_E;
  logic        JUMP_E;
  logic        BRANCH_E;
  logic [3:0]  ALU_CONTROL_E;
  logic [2:0]  F3_E;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] PC_E;
  logic [31:0] PC_PLUS4_E;
  logic [31:0] IMM_EXT_E;
  logic [4:0]  RS1_E;
  logic [4:0]  RS2_E;
  logic [4:0]  RD_E;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] BUBBLE_CNT;
  logic [31:0] STALL_CNT;
`endif

  slot_t q;
  assign q = {VALID_E, RES_SRC_E, MEM_WRITE_E, ALU_SRC_E, REG_WRITE_E, JUMP_E, BRANCH_E,
              ALU_CONTROL_E, F3_E, RD1_E, RD2_E, PC_E, PC_PLUS4_E, IMM_EXT_E,
              RS1_E, RS2_E, RD_E};

  id_ex_reg dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .EN_E          (en),
    .FLUSH_E       (fl),
    .VALID_D       (d.valid),
    .RES_SRC_D     (d.res_src),
    .MEM_WRITE_D   (d.mem_write),
    .ALU_SRC_D     (d.alu_src),
    .REG_WRITE_D   (d.reg_write),
    .JUMP_D        (d.jump),
    .BRANCH_D      (d.branch),
    .ALU_CONTROL_D (d.alu_control),
    .F3_D          (d.f3),
    .RD1_D         (d.rd1),
    .RD2_D         (d.rd2),
    .PC_D          (d.pc),
    .PC_PLUS4_D    (d.pc4),
    .IMM_EXT_D     (d.imm),
    .RS1_D         (d.rs1),
    .RS2_D         (d.rs2),
    .RD_D          (d.rd),
    .VALID_E       (VALID_E),
    .RES_SRC_E     (RES_SRC_E),
    .MEM_WRITE_E   (MEM_WRITE_E),
    .ALU_SRC_E     (ALU_SRC_E),
    .REG_WRITE_E   (REG_WRITE_E),
    .JUMP_E        (JUMP_E),
    .BRANCH_E      (BRANCH_E),
    .ALU_CONTROL_E (ALU_CONTROL_E),
    .F3_E          (F3_E),
    .RD1_E         (RD1_E),
    .RD2_E         (RD2_E),
    .PC_E          (PC_E),
    .PC_PLUS4_E    (PC_PLUS4_E),
    .IMM_EXT_E     (IMM_EXT_E),
    .RS1_E         (RS1_E),
    .RS2_E         (RS2_E),
    .RD_E          (RD_E)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .BUBBLE_CNT    (BUBBLE_CNT),
    .STALL_CNT     (STALL_CNT)
`endif
  );

  always #5 clk = ~clk;

  slot_t exp_q[$];
  slot_t model = '0;
  int    n_vec = 0;
  int    n_err = 0;
  bit    mon_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: what the E stage should hold after one edge, from the stated rules.
  function automatic slot_t scrub(slot_t s);
    slot_t r;
    r             = s;
    r.valid       = (s.valid === 1'b1);
    r.mem_write   = (s.mem_write === 1'b1);
    r.alu_src     = (s.alu_src === 1'b1);
    r.reg_write   = (s.reg_write === 1'b1);
    r.jump        = (s.jump === 1'b1);
    r.branch      = (s.branch === 1'b1);
    r.res_src     = $isunknown(s.res_src) ? 2'b00 : s.res_src;
    r.alu_control = $isunknown(s.alu_control) ? 4'b0000 : s.alu_control;
    r.f3          = $isunknown(s.f3) ? 3'b000 : s.f3;
    return r;
  endfunction

  function automatic slot_t ref_next(slot_t cur, slot_t din, logic e, logic f);
    slot_t s;
    s = scrub(din);
    if (f) return '0;
    if (e) return s.valid ? s : '0;
    return cur;
  endfunction

  function automatic slot_t rand_slot();
    slot_t s;
    s.valid       = ($urandom_range(0, 3) != 0);
    s.res_src     = 2'($urandom_range(0, 3));
    s.mem_write   = 1'($urandom_range(0, 1));
    s.alu_src     = 1'($urandom_range(0, 1));
    s.reg_write   = 1'($urandom_range(0, 1));
    s.jump        = 1'($urandom_range(0, 1));
    s.branch      = 1'($urandom_range(0, 1));
    s.alu_control = 4'($urandom_range(0, 15));
    s.f3          = 3'($urandom_range(0, 7));
    s.rd1         = $urandom;
    s.rd2         = $urandom;
    s.pc          = $urandom;
    s.pc4         = $urandom;
    s.imm         = $urandom;
    s.rs1         = 5'($urandom_range(0, 31));
    s.rs2         = 5'($urandom_range(0, 31));
    s.rd          = 5'($urandom_range(0, 31));
    return s;
  endfunction

  // Called away from the edge: apply controls, advance the model, check after the edge.
  task automatic step(input logic e, input logic f, input string name);
    en    = e;
    fl    = f;
    model = ref_next(model, d, e, f);
    @(posedge clk);
    #1;
    check(name, 256'(q), 256'(model));
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: got empty queue expected one entry");
      end else begin
        slot_t e;
        e = exp_q.pop_front();
        check("sb_slot", 256'(q), 256'(e));
        if (!q.valid) check("bubble_side_effect", 256'({q.reg_write, q.mem_write}), 256'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    slot_t saved;
    #2;
    check("reset_state", 256'(q), 256'(0));
    d       = rand_slot();
    d.valid = 1'b1;
    en      = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ignores_edge", 256'(q), 256'(0));

    // ADD capture, then asynchronous reset between edges.
    @(negedge clk);
    rst_n       = 1'b1;
    d           = '0;
    d.valid     = 1'b1;
    d.reg_write = 1'b1;
    d.rd        = 5'd5;
    step(1'b1, 1'b0, "add_slot");
    check("add_reg_write", 256'(q.reg_write), 256'(1));
    check("add_rd", 256'(q.rd), 256'(5));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 256'(q), 256'(0));
    model = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Store-type capture.
    d           = '0;
    d.valid     = 1'b1;
    d.mem_write = 1'b1;
    d.alu_src   = 1'b1;
    d.rd1       = 32'h100;
    d.imm       = 32'h8;
    d.rs1       = 5'd2;
    d.rs2       = 5'd3;
    step(1'b1, 1'b0, "sw_slot");
    check("sw_mem_write", 256'(q.mem_write), 256'(1));
    check("sw_rd1", 256'(q.rd1), 256'(32'h100));
    check("sw_imm", 256'(q.imm), 256'(32'h8));
    check("sw_valid", 256'(q.valid), 256'(1));

    // Hold for three cycles while D churns.
    saved = model;
    for (int i = 0; i < 3; i++) begin
      d = rand_slot();
      step(1'b0, 1'b0, "hold_slot");
      check("hold_unchanged", 256'(q), 256'(saved));
    end
`ifdef ID_EX_PERF_CNT_EN
    check("stall_cnt", 256'(STALL_CNT), 256'(3));
`endif

    // Flush wins over hold.
    d           = '0;
    d.valid     = 1'b1;
    d.reg_write = 1'b1;
    d.rd        = 5'd7;
    step(1'b0, 1'b1, "flush_slot");
    check("flush_valid", 256'(q.valid), 256'(0));
    check("flush_reg_write", 256'(q.reg_write), 256'(0));
    check("flush_rd", 256'(q.rd), 256'(0));
`ifdef ID_EX_PERF_CNT_EN
    check("bubble_cnt", 256'(BUBBLE_CNT), 256'(1));
`endif

    // JAL with undefined ALU fields.
    d             = '0;
    d.valid       = 1'b1;
    d.jump        = 1'b1;
    d.reg_write   = 1'b1;
    d.res_src     = 2'b10;
    d.rd          = 5'd1;
    d.alu_control = 4'bxxxx;
    d.alu_src     = 1'bx;
    step(1'b1, 1'b0, "jal_slot");
    check("jal_alu_control", 256'(q.alu_control), 256'(model.alu_control));
    check("jal_alu_src", 256'(q.alu_src), 256'(model.alu_src));
    check("jal_jump", 256'(q.jump), 256'(1));
    check("jal_res_src", 256'(q.res_src), 256'(2'b10));

    // Enabled but empty D slot becomes a bubble.
    d           = rand_slot();
    d.valid     = 1'b0;
    d.mem_write = 1'b1;
    d.reg_write = 1'b1;
    step(1'b1, 1'b0, "invalid_slot");
    check("invalid_mem_write", 256'(q.mem_write), 256'(0));
    check("invalid_reg_write", 256'(q.reg_write), 256'(0));

`ifdef ID_EX_PERF_CNT_EN
    force dut.r_bubble_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_bubble_cnt;
    step(1'b0, 1'b1, "wrap_slot");
    check("bubble_wrap", 256'(BUBBLE_CNT), 256'(0));
`endif

    // Randomized run through the scoreboard.
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      d     = rand_slot();
      en    = ($urandom_range(0, 4) != 0);
      fl    = ($urandom_range(0, 6) == 0);
      model = ref_next(model, d, en, fl);
      exp_q.push_back(model);
      mon_en = 1'b1;
      $display("txn %0d en=%0b flush=%0b valid_d=%0b rd=%0d", t, en, fl, d.valid, d.rd);
    end
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    check("sb_drained", 256'(exp_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Decode-to-execute pipeline register of the 5-stage RV32I core, directly downstream of the decode-stage control unit and register file.
- Captures the decoded control bundle (RES_SRC, MEM_WRITE, ALU_SRC, REG_WRITE, JUMP, BRANCH, ALU_CONTROL) and the datapath operands.
- Presents them to the execute stage one cycle later.
- Supports hold (enable low), flush (bubble insertion) and a valid bit.
- Scrubs unused/X control values so execute-stage logic never sees X.

Parameters:
- XLEN, 32, datapath width (operands, PC, immediate).
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- EN_E  in  1  1 = capture the D-stage inputs; 0 = hold current contents.
- FLUSH_E  in  1  1 = load a bubble at the next edge (load-use stall or taken branch/jump).
- VALID_D  in  1  the D-stage slot holds a real instruction.
- RES_SRC_D  in  2  result-mux select.
- MEM_WRITE_D, ALU_SRC_D, REG_WRITE_D, JUMP_D, BRANCH_D  in  1 each  decoded control.
- ALU_CONTROL_D  in  4  ALU opcode.
- F3_D  in  3  funct3, used by the execute-stage branch comparator.
- RD1_D, RD2_D  in  XLEN  register operands.
- PC_D, PC_PLUS4_D, IMM_EXT_D  in  XLEN  PC, PC+4, extended immediate.
- RS1_D, RS2_D, RD_D  in  REG_AW  register indices (used by the forwarding unit).
- Outputs, one per D input: VALID_E, RES_SRC_E, MEM_WRITE_E, ALU_SRC_E, REG_WRITE_E, JUMP_E, BRANCH_E, ALU_CONTROL_E, F3_E, RD1_E, RD2_E, PC_E, PC_PLUS4_E, IMM_EXT_E, RS1_E, RS2_E, RD_E. Each is out, with the same width as its input, and is the registered copy.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-hold or mid-flush):
  - all outputs go to 0 immediately.
  - RES_SRC_E=00, ALU_CONTROL_E=0000, VALID_E=0.
  - State stays 0 while rst_n is low.
  - The first capture happens on the first rising edge after deassertion.
- Priority at each rising edge is reset > FLUSH_E > EN_E.
- FLUSH_E=1, regardless of EN_E:
  - load a bubble: VALID_E=0; REG_WRITE_E, MEM_WRITE_E, JUMP_E, BRANCH_E = 0.
  - RES_SRC_E=00, ALU_SRC_E=0, ALU_CONTROL_E=0000, F3_E=000.
  - RD_E, RS1_E, RS2_E = 0, so the hazard unit sees x0 and no false dependency.
  - Data fields (RD1/RD2/PC/PC_PLUS4/IMM) are don't-care and are loaded with 0.
- FLUSH_E=0, EN_E=1:
  - If VALID_D=1: every output takes its D input (latency one cycle).
  - If VALID_D=0: load a bubble exactly as for a flush.
- FLUSH_E=0, EN_E=0: all outputs hold, including VALID_E.
- X scrubbing:
  - Every 1-bit control input that is not 1'b1 is captured as 0.
  - Every multi-bit control input containing X/Z is captured as all-zero.
  - Implemented as a case-equality sanitize stage feeding the flops; it is transparent in synthesis.
  - This absorbs don't-care encodings the decoder emits for unused fields (e.g. ALU_CONTROL on JAL/AUIPC, RES_SRC on stores and branches).
- Side-effect-free control: a bubble must never have REG_WRITE_E=1 or MEM_WRITE_E=1.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Enabled:
  - adds outputs BUBBLE_CNT (32, out) and STALL_CNT (32, out).
  - BUBBLE_CNT increments on each edge that loads a bubble (flush, or EN_E=1 with VALID_D=0).
  - STALL_CNT increments on each edge with EN_E=0 and FLUSH_E=0.
  - Both counters reset to 0 asynchronously and wrap from 0xFFFFFFFF to 0.
- Disabled: neither port nor the counter logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package rv_pipe_pkg:
  - RES_SRC encodings: ALU=00, MEM=01, PC4=10, PCT=11.
  - ALU_CONTROL encodings: ADD 0000, SUB 0001, AND 0100, OR 0101, XOR 0110, SLT 1000, SLTU 1001, SRL 1101, SLL 1110, SRA 1111.
  - The bubble constant for the control bundle.
  - A packed ctrl_bundle_t typedef.
- Sub-module ctrl_sanitize: combinational X-scrub of the control bundle. It is reused by the EX/MEM register.

Test Plan:
- Reset mid-operation: capture an ADD (REG_WRITE_D=1, ALU_CONTROL_D=0000, RD_D=5), then pull rst_n low between edges -> all outputs 0 immediately, without waiting for a clock edge.
- Normal capture: VALID_D=1, EN_E=1, sw-type bundle (MEM_WRITE_D=1, ALU_SRC_D=1, RD1_D=0x100, IMM_EXT_D=0x8) -> next cycle MEM_WRITE_E=1, RD1_E=0x100, IMM_EXT_E=0x8, VALID_E=1.
- Hold: EN_E=0 for 3 cycles while the D inputs change -> outputs unchanged; with ID_EX_PERF_CNT_EN, STALL_CNT=3.
- Flush beats hold: FLUSH_E=1, EN_E=0, D has REG_WRITE_D=1, RD_D=7 -> next cycle VALID_E=0, REG_WRITE_E=0, RD_E=0.
- X scrub: JAL bundle with ALU_CONTROL_D=4'bxxxx, ALU_SRC_D=1'bx -> ALU_CONTROL_E=0000, ALU_SRC_E=0, JUMP_E=1, RES_SRC_E=10.
- Counter wrap: force BUBBLE_CNT=0xFFFFFFFF, then apply one flush -> BUBBLE_CNT=0.
